demux14_lane_reg: RTL and testbench
===================================

// Module: demux14_lane_reg
// PURPOSE
//   1:4 registered demultiplexer: the distribution end of the 4:1 select path used by the
//   universal shift register. One WIDTH-bit input stream is steered to one of four
//   holding lanes (A..D), chosen either by s0/s1 or by an internal round-robin pointer.
//   Each lane has a valid/ack handshake toward its consumer. Backpressure reaches the
//   source through din_ready.
// PARAMETERS
//   WIDTH  4  data width of din and each lane output
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous, active-low reset
//   din        in   WIDTH  input word
//   din_valid  in   1      source presents din this cycle
//   din_ready  out  1      block accepts din this cycle (combinational)
//   s0, s1     in   1      lane select; {s0,s1}: 00=A, 01=B, 10=C, 11=D
//   rr_en      in   1      1 = use internal round-robin pointer, ignore s0/s1
//   oa..od     out  WIDTH  lane A..D held data
//   lane_vld   out  4      per-lane valid; bit0=A .. bit3=D
//   lane_ack   in   4      per-lane consume strobe; bit0=A .. bit3=D
//   rr_ptr     out  2      current round-robin pointer (debug/observe)
// BEHAVIOUR
//   - Clock and reset: one clock; reset is asynchronous and active-low.
//     While rst_n=0: oa..od=0, lane_vld=0000, rr_ptr=00. din_ready is combinational
//     and reads the reset lane state, so it is 1 during reset.
//   - sel = rr_en ? rr_ptr : {s0,s1}. The value is evaluated combinationally every cycle.
//   - din_ready = ~lane_vld[sel] | lane_ack[sel].
//     * A lane may be refilled in the same cycle it is consumed.
//     * There is a combinational path lane_ack -> din_ready.
//   - Accept = din_valid & din_ready. On accept, the selected lane loads din and its
//     valid bit is 1 the next cycle. Latency is 1 cycle from din to lane output.
//   - Lane update priority, per lane per cycle:
//     * accept into this lane -> data <= din, vld <= 1. This wins over a simultaneous ack.
//     * else ack & vld -> vld <= 0. Data is held; it is not cleared.
//     * ack while vld=0 -> ignored.
//   - Lane data is stable while vld=1 and no accept targets that lane.
//   - rr_ptr advances only on accept while rr_en=1, wrapping 3 -> 0. A stalled cycle
//     (din_valid & ~din_ready) does not advance it.
//   - With rr_en=0, rr_ptr holds its value. Toggling rr_en resumes from the stored pointer;
//     the pointer is not reset.
//   - din_valid=0 -> no state change except acks.
//   - Source rule: once din_valid=1 and the transfer is stalled, the source holds din until
//     accepted. The block does not check this rule.
//   - Reset asserted mid-transfer discards all lane contents immediately. No partial state
//     survives.
// STRUCTURE
//   - Shared package: lane encoding constants LANE_A=2'b00, LANE_B=2'b01, LANE_C=2'b10,
//     LANE_D=2'b11; NUM_LANES=4.
//   - Sub-module demux_lane_reg: one WIDTH-bit holding register with vld, inputs
//     load/din/ack, outputs q/vld. It implements the priority rule above and is
//     instantiated 4x.
//   - The top level holds the select decode (inverse of the 4:1 AND-OR mux), the rr_ptr
//     counter and the din_ready mux.
// TESTING
//   1. Reset check: hold rst_n=0 with din_valid=1 -> lane_vld=0000, rr_ptr=00, no lane
//      loads. Release reset -> idle.
//   2. Manual steering: rr_en=0; send 4'h3 to {s0,s1}=10, then 4'h9 to 01.
//      -> oc=3, vld[2]=1 one cycle later; ob=9, vld[1]=1. oa and od are untouched.
//   3. Round-robin: rr_en=1, all acks=1, stream 1,2,3,4,5.
//      -> lands in A,B,C,D,A; rr_ptr sequence 0,1,2,3,0,1; din_ready=1 throughout.
//   4. Full/backpressure: rr_en=0, sel=A, no ack. Write 4'h5, then present 4'h6.
//      -> din_ready=0, oa stays 5. Pulse lane_ack[0] -> 6 accepted in that same cycle,
//      vld[0] stays 1.
//   5. Stall pointer: rr_en=1, lane B full and unacked, rr_ptr=1, din_valid=1.
//      -> rr_ptr stays 1 for 5 cycles. Ack B -> accept, rr_ptr becomes 2.
//   6. Reset mid-operation: lanes A and C valid, assert rst_n=0 asynchronously between
//      edges -> lane_vld=0000 and outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/demux14_lane_reg_pkg.sv
// Shared constants for the 1:4 registered lane demultiplexer.
//   LANE_A..LANE_D : lane select encoding, matches {s0,s1} and the rr_ptr value
//   NUM_LANES      : number of holding lanes
package demux14_lane_reg_pkg;

  localparam int NUM_LANES = 4;

  localparam logic [1:0] LANE_A = 2'b00;
  localparam logic [1:0] LANE_B = 2'b01;
  localparam logic [1:0] LANE_C = 2'b10;
  localparam logic [1:0] LANE_D = 2'b11;

endpackage

// File: rtl/demux14_lane_reg_lane.sv
// demux_lane_reg: one holding lane of the demultiplexer.
// A WIDTH-bit data register plus a valid bit with consumer acknowledge.
//   clk, rst_n : clock, asynchronous active-low reset (clears data and valid)
//   load_i     : an accepted word targets this lane this cycle
//   din_i      : word to store on load
//   ack_i      : consumer takes the held word this cycle
//   q_o        : held data
//   vld_o      : held data is valid
module demux_lane_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             ack_i,
  output logic [WIDTH-1:0] q_o,
  output logic             vld_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             vld_q, vld_d;

  // A load wins over a simultaneous ack so a lane can be refilled in the
  // same cycle it is drained. An ack only clears valid; data is kept.
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (load_i) begin
      data_d = din_i;
      vld_d  = 1'b1;
    end else if (ack_i && vld_q) begin
      vld_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign q_o   = data_q;
  assign vld_o = vld_q;

endmodule

// File: rtl/demux14_lane_reg.sv
// demux14_lane_reg: 1:4 registered demultiplexer with per-lane valid/ack.
// One input stream is steered into one of four holding lanes, selected either
// by {s0,s1} or by an internal round-robin pointer.
//   clk, rst_n      : clock, asynchronous active-low reset
//   din, din_valid  : source word and its valid
//   din_ready       : combinational; selected lane is empty or being acked
//   s0, s1          : manual lane select {s0,s1}: 00=A 01=B 10=C 11=D
//   rr_en           : 1 = select with rr_ptr instead of s0/s1
//   oa..od          : lane A..D held data
//   lane_vld        : per-lane valid, bit0=A .. bit3=D
//   lane_ack        : per-lane consume strobe, bit0=A .. bit3=D
//   rr_ptr          : current round-robin pointer
module demux14_lane_reg
  import demux14_lane_reg_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             s0,
  input  logic             s1,
  input  logic             rr_en,
  output logic [WIDTH-1:0] oa,
  output logic [WIDTH-1:0] ob,
  output logic [WIDTH-1:0] oc,
  output logic [WIDTH-1:0] od,
  output logic [3:0]       lane_vld,
  input  logic [3:0]       lane_ack,
  output logic [1:0]       rr_ptr
);

  logic [1:0]           sel;
  logic                 accept;
  logic [NUM_LANES-1:0] load;
  logic [1:0]           rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]     lane_q [NUM_LANES];

  assign sel = rr_en ? rr_ptr_q : {s0, s1};

  // Ready looks at the lane state live, so an ack this cycle frees the lane
  // for the word presented in the same cycle.
  assign din_ready = ~lane_vld[sel] | lane_ack[sel];
  assign accept    = din_valid & din_ready;

  // One-hot decode of the select: the inverse of the 4:1 AND-OR mux.
  always_comb begin
    load = '0;
    if (accept) begin
      load[sel] = 1'b1;
    end
  end

  // The pointer only moves on a real transfer, so a stalled word retries
  // the same lane; with rr_en low it is frozen, not reset.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept && rr_en) begin
      rr_ptr_d = rr_ptr_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= LANE_A;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    demux_lane_reg #(
      .WIDTH (WIDTH)
    ) u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (load[i]),
      .din_i  (din),
      .ack_i  (lane_ack[i]),
      .q_o    (lane_q[i]),
      .vld_o  (lane_vld[i])
    );
  end

  assign oa     = lane_q[LANE_A];
  assign ob     = lane_q[LANE_B];
  assign oc     = lane_q[LANE_C];
  assign od     = lane_q[LANE_D];
  assign rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_demux14_lane_reg.sv
module tb_demux14_lane_reg;

  logic       clk;
  logic       rst_n;
  logic [3:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       s0, s1;
  logic       rr_en;
  logic [3:0] oa, ob, oc, od;
  logic [3:0] lane_vld;
  logic [3:0] lane_ack;
  logic [1:0] rr_ptr;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] din;
    logic       valid;
    logic [1:0] s;        // {s0,s1}
    logic       rr;
    logic [3:0] ack;
    logic       exp_ready;
    logic [1:0] exp_lane; // lane the word should land in when accepted
    logic [3:0] exp_vld;  // lane_vld after the edge
    logic [1:0] exp_ptr;  // rr_ptr after the edge
  } vec_t;

  typedef struct {
    logic [1:0] lane;
    logic [3:0] data;
  } sb_t;

  sb_t  sbq[$];
  vec_t tbl[8];

  demux14_lane_reg #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .s0        (s0),
    .s1        (s1),
    .rr_en     (rr_en),
    .oa        (oa),
    .ob        (ob),
    .oc        (oc),
    .od        (od),
    .lane_vld  (lane_vld),
    .lane_ack  (lane_ack),
    .rr_ptr    (rr_ptr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] lane_out(input logic [1:0] l);
    case (l)
      2'd0:    return oa;
      2'd1:    return ob;
      2'd2:    return oc;
      default: return od;
    endcase
  endfunction

  // Drive one cycle of stimulus, check ready before the edge, then check
  // lane state after the edge and retire scoreboard entries.
  task automatic apply(input vec_t v, input string tag);
    sb_t e;
    din       = v.din;
    din_valid = v.valid;
    s0        = v.s[1];
    s1        = v.s[0];
    rr_en     = v.rr;
    lane_ack  = v.ack;
    #1;
    chk({tag, " din_ready"}, 32'(din_ready), 32'(v.exp_ready));
    if (v.valid && v.exp_ready) sbq.push_back('{lane: v.exp_lane, data: v.din});
    @(posedge clk);
    #1;
    chk({tag, " lane_vld"}, 32'(lane_vld), 32'(v.exp_vld));
    chk({tag, " rr_ptr"}, 32'(rr_ptr), 32'(v.exp_ptr));
    while (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk({tag, " lane data"}, 32'(lane_out(e.lane)), 32'(e.data));
      chk({tag, " lane valid"}, 32'(lane_vld[e.lane]), 32'd1);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] d, input logic v, input logic [1:0] s,
                              input logic rr, input logic [3:0] ack, input logic er,
                              input logic [1:0] el, input logic [3:0] ev, input logic [1:0] ep);
    vec_t r;
    r.din = d; r.valid = v; r.s = s; r.rr = rr; r.ack = ack;
    r.exp_ready = er; r.exp_lane = el; r.exp_vld = ev; r.exp_ptr = ep;
    return r;
  endfunction

  initial begin
    // Manual steering, then round-robin with all acks, then drain.
    tbl[0] = mk(4'h3, 1, 2'b10, 0, 4'b0000, 1, 2'd2, 4'b0100, 2'd0);
    tbl[1] = mk(4'h9, 1, 2'b01, 0, 4'b0000, 1, 2'd1, 4'b0110, 2'd0);
    tbl[2] = mk(4'h1, 1, 2'b00, 1, 4'b1111, 1, 2'd0, 4'b0001, 2'd1);
    tbl[3] = mk(4'h2, 1, 2'b00, 1, 4'b1111, 1, 2'd1, 4'b0010, 2'd2);
    tbl[4] = mk(4'h3, 1, 2'b00, 1, 4'b1111, 1, 2'd2, 4'b0100, 2'd3);
    tbl[5] = mk(4'h4, 1, 2'b00, 1, 4'b1111, 1, 2'd3, 4'b1000, 2'd0);
    tbl[6] = mk(4'h5, 1, 2'b00, 1, 4'b1111, 1, 2'd0, 4'b0001, 2'd1);
    tbl[7] = mk(4'h0, 0, 2'b00, 0, 4'b1111, 1, 2'd0, 4'b0000, 2'd1);

    // Reset held with a valid source: nothing may load.
    rst_n = 1'b0; din = 4'hF; din_valid = 1'b1; s0 = 0; s1 = 0; rr_en = 0; lane_ack = 4'b0000;
    repeat (3) @(posedge clk);
    #1;
    chk("reset lane_vld", 32'(lane_vld), 32'd0);
    chk("reset rr_ptr", 32'(rr_ptr), 32'd0);
    chk("reset oa", 32'(oa), 32'd0);
    chk("reset din_ready", 32'(din_ready), 32'd1);
    din_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("idle lane_vld", 32'(lane_vld), 32'd0);

    for (int i = 0; i < 8; i++) begin
      apply(tbl[i], $sformatf("tbl%0d", i));
      if (i == 1) begin
        chk("steer oa untouched", 32'(oa), 32'd0);
        chk("steer od untouched", 32'(od), 32'd0);
      end
    end

    // Backpressure on lane A, refill in the ack cycle, then data held after ack.
    apply(mk(4'h5, 1, 2'b00, 0, 4'b0000, 1, 2'd0, 4'b0001, 2'd1), "bp write5");
    apply(mk(4'h6, 1, 2'b00, 0, 4'b0000, 0, 2'd0, 4'b0001, 2'd1), "bp stall1");
    chk("bp oa held", 32'(oa), 32'h5);
    apply(mk(4'h6, 1, 2'b00, 0, 4'b0000, 0, 2'd0, 4'b0001, 2'd1), "bp stall2");
    chk("bp oa held2", 32'(oa), 32'h5);
    apply(mk(4'h6, 1, 2'b00, 0, 4'b0001, 1, 2'd0, 4'b0001, 2'd1), "bp refill");
    apply(mk(4'h0, 0, 2'b00, 0, 4'b0001, 1, 2'd0, 4'b0000, 2'd1), "bp consume");
    chk("bp data kept after ack", 32'(oa), 32'h6);

    // Stalled round-robin pointer: fill B manually, then retry B via rr.
    apply(mk(4'h7, 1, 2'b01, 0, 4'b0000, 1, 2'd1, 4'b0010, 2'd1), "stall fillB");
    for (int k = 0; k < 5; k++)
      apply(mk(4'h8, 1, 2'b00, 1, 4'b0000, 0, 2'd1, 4'b0010, 2'd1), $sformatf("stall%0d", k));
    chk("stall ob held", 32'(ob), 32'h7);
    apply(mk(4'h8, 1, 2'b00, 1, 4'b0010, 1, 2'd1, 4'b0010, 2'd2), "stall release");

    // Asynchronous reset between edges with lanes A and C valid.
    apply(mk(4'hA, 1, 2'b00, 0, 4'b0000, 1, 2'd0, 4'b0011, 2'd2), "mid fillA");
    apply(mk(4'hC, 1, 2'b10, 0, 4'b0000, 1, 2'd2, 4'b0111, 2'd2), "mid fillC");
    din_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async lane_vld", 32'(lane_vld), 32'd0);
    chk("async oa", 32'(oa), 32'd0);
    chk("async ob", 32'(ob), 32'd0);
    chk("async oc", 32'(oc), 32'd0);
    chk("async rr_ptr", 32'(rr_ptr), 32'd0);
    chk("async din_ready", 32'(din_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post reset lane_vld", 32'(lane_vld), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
